// File: rtl/lookup_table_db.sv
// Double-buffered lookup table: AXI-Stream addresses read the active bank while a
// load stream fills the shadow bank. Define LOOKUP_TABLE_DB_OUTREG_EN for a 2-stage output.
module lookup_table_db #(
  parameter int TDATA_WIDTH   = 32,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [ADDRESS_WIDTH-1:0] data_in_tdata,
  input  logic                     data_in_tvalid,
  input  logic                     data_in_tlast,
  output logic                     data_in_tready,
  output logic [TDATA_WIDTH-1:0]   data_out_tdata,
  output logic                     data_out_tvalid,
  output logic                     data_out_tlast,
  input  logic                     data_out_tready,
  input  logic [TDATA_WIDTH-1:0]   data_load_tdata,
  input  logic                     data_load_tvalid,
  input  logic                     data_load_tlast,
  output logic                     data_load_tready,
  output logic                     active_bank,
  output logic                     swap_pending,
  output logic                     load_overflow
);

  logic [TDATA_WIDTH-1:0]   r_mem [0:(2**(ADDRESS_WIDTH+1))-1];
  logic [TDATA_WIDTH-1:0]   r_rd_data;
  logic                     r_s1_valid;
  logic                     r_s1_last;
  logic                     r_active_bank;
  logic                     r_swap_pending;
  logic                     r_load_overflow;
  logic                     r_in_packet;
  logic [ADDRESS_WIDTH-1:0] r_load_addr;
  logic                     r_load_full;

  logic w_s1_adv;
  logic w_in_accept;
  logic w_load_accept;
  logic w_wr_en;
  logic w_swap;

`ifdef LOOKUP_TABLE_DB_OUTREG_EN
  logic                   r_s2_valid;
  logic                   r_s2_last;
  logic [TDATA_WIDTH-1:0] r_s2_data;
  logic                   w_s2_adv;

  assign w_s2_adv = !r_s2_valid || data_out_tready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_s2_adv && r_s1_valid) r_s2_data <= r_rd_data;
  end

  assign data_out_tvalid = r_s2_valid;
  assign data_out_tlast  = r_s2_last;
  assign data_out_tdata  = r_s2_data;
`else
  assign w_s1_adv        = !r_s1_valid || data_out_tready;
  assign data_out_tvalid = r_s1_valid;
  assign data_out_tlast  = r_s1_last;
  assign data_out_tdata  = r_rd_data;
`endif

  assign data_in_tready   = w_s1_adv;
  assign w_in_accept      = data_in_tvalid && w_s1_adv;
  assign data_load_tready = !r_swap_pending;
  assign w_load_accept    = data_load_tvalid && !r_swap_pending;
  assign w_wr_en          = w_load_accept && !r_load_full;

  // Swap only on a packet boundary so a packet never mixes entries from two tables.
  assign w_swap = r_swap_pending &&
                  ((!r_in_packet && !(w_in_accept && !data_in_tlast)) ||
                   (w_in_accept && data_in_tlast));

  // NOTE: the table and its read register have no reset; a reset term would stop RAM inference.
  always_ff @(posedge aclk) begin
    if (w_wr_en)     r_mem[{~r_active_bank, r_load_addr}] <= data_load_tdata;
    if (w_in_accept) r_rd_data <= r_mem[{r_active_bank, data_in_tdata}];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
    end else if (w_s1_adv) begin
      // NOTE: non-blocking assignments make every register sample pre-edge values.
      r_s1_valid <= data_in_tvalid;
      r_s1_last  <= data_in_tvalid && data_in_tlast;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_active_bank   <= 1'b0;
      r_swap_pending  <= 1'b0;
      r_load_overflow <= 1'b0;
      r_in_packet     <= 1'b0;
      r_load_addr     <= '0;
      r_load_full     <= 1'b0;
    end else begin
      if (w_in_accept) r_in_packet <= !data_in_tlast;
      if (w_swap) begin
        r_active_bank  <= !r_active_bank;
        r_swap_pending <= 1'b0;
      end
      if (w_load_accept) begin
        if (r_load_full) r_load_overflow <= 1'b1;
        if (data_load_tlast) begin
          r_load_addr    <= '0;
          r_load_full    <= 1'b0;
          r_swap_pending <= 1'b1;
        end else if (!r_load_full) begin
          // Terminal address is held once the last entry is written.
          if (r_load_addr == '1) r_load_full <= 1'b1;
          else                   r_load_addr <= r_load_addr + 1'b1;
        end
      end
    end
  end

  assign active_bank   = r_active_bank;
  assign swap_pending  = r_swap_pending;
  assign load_overflow = r_load_overflow;

endmodule

// File: tb/tb_lookup_table_db.sv
// Randomised bench for lookup_table_db against a bank/queue reference model.
module tb_lookup_table_db;
  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
`ifdef LOOKUP_TABLE_DB_OUTREG_EN
  localparam bit ONE_CYCLE = 1'b0;
`else
  localparam bit ONE_CYCLE = 1'b1;
`endif

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [AW-1:0] data_in_tdata;
  logic          data_in_tvalid, data_in_tlast, data_in_tready;
  logic [DW-1:0] data_out_tdata;
  logic          data_out_tvalid, data_out_tlast, data_out_tready;
  logic [DW-1:0] data_load_tdata;
  logic          data_load_tvalid, data_load_tlast, data_load_tready;
  logic          active_bank, swap_pending, load_overflow;

  lookup_table_db #(.TDATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .data_in_tdata(data_in_tdata), .data_in_tvalid(data_in_tvalid),
    .data_in_tlast(data_in_tlast), .data_in_tready(data_in_tready),
    .data_out_tdata(data_out_tdata), .data_out_tvalid(data_out_tvalid),
    .data_out_tlast(data_out_tlast), .data_out_tready(data_out_tready),
    .data_load_tdata(data_load_tdata), .data_load_tvalid(data_load_tvalid),
    .data_load_tlast(data_load_tlast), .data_load_tready(data_load_tready),
    .active_bank(active_bank), .swap_pending(swap_pending), .load_overflow(load_overflow)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  int     n_total = 0;
  int     n_pass  = 0;
  beat_t  exp_q[$];
  logic [DW-1:0] m_mem [2][DEPTH];
  bit     m_active, m_pending, m_ovf, m_in_pkt;
  int     m_ld_cnt;
  bit     prev_stall;
  logic [DW-1:0] prev_data;
  logic   prev_last;
  int     g_pkt, g_in_idx, g_ld_len, g_ld_base, g_ld_idx;
  bit     g_seq;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock cycle: compare outputs, then advance the model by the handshakes seen.
  task automatic tick(output bit acc_in, output bit acc_ld);
    beat_t b;
    bit    swap;
    #1;
    check("active_bank", active_bank, m_active);
    check("swap_pending", swap_pending, m_pending);
    check("load_overflow", load_overflow, m_ovf);
    check("load_tready", data_load_tready, !m_pending);
    if (ONE_CYCLE) check("in_tready", data_in_tready, !data_out_tvalid || data_out_tready);
    if (prev_stall) begin
      check("hold_valid", data_out_tvalid, 1'b1);
      check("hold_data", data_out_tdata, prev_data);
      check("hold_last", data_out_tlast, prev_last);
    end
    if (data_out_tvalid && data_out_tready) begin
      if (exp_q.size() == 0) check("unexpected_beat", 1'b1, 1'b0);
      else begin
        b = exp_q.pop_front();
        check("out_data", data_out_tdata, b.data);
        check("out_last", data_out_tlast, b.last);
      end
    end
    prev_stall = data_out_tvalid && !data_out_tready;
    prev_data  = data_out_tdata;
    prev_last  = data_out_tlast;

    acc_in = data_in_tvalid && data_in_tready;
    acc_ld = data_load_tvalid && data_load_tready;
    if (acc_in) begin
      b.data = m_mem[m_active][data_in_tdata];
      b.last = data_in_tlast;
      exp_q.push_back(b);
    end
    swap = m_pending && ((!m_in_pkt && !(acc_in && !data_in_tlast)) || (acc_in && data_in_tlast));
    if (acc_in) m_in_pkt = !data_in_tlast;
    if (acc_ld) begin
      if (m_ld_cnt < DEPTH) m_mem[!m_active][m_ld_cnt] = data_load_tdata;
      else                  m_ovf = 1'b1;
      if (data_load_tlast) begin
        m_ld_cnt  = 0;
        m_pending = 1'b1;
      end else m_ld_cnt++;
    end
    if (swap) begin
      m_active  = !m_active;
      m_pending = 1'b0;
    end
    @(negedge aclk);
  endtask

  task automatic drive_and_tick(input int p_in, input int p_rdy, input int p_ld,
                                input int in_left, input int ld_left,
                                output bit acc_in, output bit acc_ld);
    if (!data_in_tvalid && in_left > 0 && $urandom_range(99) < p_in) begin
      data_in_tvalid = 1'b1;
      data_in_tdata  = g_seq ? AW'(g_in_idx) : AW'($urandom);
      data_in_tlast  = (g_in_idx % g_pkt) == g_pkt - 1;
    end
    if (!data_load_tvalid && ld_left > 0 && $urandom_range(99) < p_ld) begin
      data_load_tvalid = 1'b1;
      data_load_tdata  = DW'(g_ld_base + g_ld_idx);
      data_load_tlast  = g_ld_idx == g_ld_len - 1;
    end
    data_out_tready = $urandom_range(99) < p_rdy;
    tick(acc_in, acc_ld);
    if (acc_in) begin
      data_in_tvalid = 1'b0;
      g_in_idx++;
    end
    if (acc_ld) begin
      data_load_tvalid = 1'b0;
      g_ld_idx++;
    end
  endtask

  task automatic run(input int n_in, input int n_ld, input int p_in, input int p_rdy, input int p_ld);
    int in_done = 0;
    int ld_done = 0;
    int cyc     = 0;
    bit ai, al;
    while ((in_done < n_in || ld_done < n_ld) && cyc < 20000) begin
      drive_and_tick(p_in, p_rdy, p_ld, n_in - in_done, n_ld - ld_done, ai, al);
      in_done += int'(ai);
      ld_done += int'(al);
      cyc++;
    end
    if (cyc >= 20000) check("run_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    int cyc = 0;
    bit ai, al;
    while ((exp_q.size() > 0 || data_out_tvalid) && cyc < 50) begin
      drive_and_tick(0, 100, 0, 0, 0, ai, al);
      cyc++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    bit ai, al;
    aresetn = 1'b0;
    data_in_tdata = '0;   data_in_tvalid = 1'b0;   data_in_tlast = 1'b0;
    data_load_tdata = '0; data_load_tvalid = 1'b0; data_load_tlast = 1'b0;
    data_out_tready = 1'b0;
    m_active = 1'b0; m_pending = 1'b0; m_ovf = 1'b0; m_in_pkt = 1'b0; m_ld_cnt = 0;
    prev_stall = 1'b0;
    repeat (2) @(negedge aclk);
    check("rst_out_valid", data_out_tvalid, 1'b0);
    check("rst_out_last", data_out_tlast, 1'b0);
    check("rst_active_bank", active_bank, 1'b0);
    check("rst_swap_pending", swap_pending, 1'b0);
    check("rst_overflow", load_overflow, 1'b0);
    check("rst_load_tready", data_load_tready, 1'b1);
    aresetn = 1'b1;
    @(negedge aclk);

    // Latency of a single isolated beat.
    g_seq = 1'b1; g_pkt = 1; g_in_idx = 0;
    drive_and_tick(100, 100, 0, 1, 0, ai, al);
    check("first_accept", ai, 1'b1);
    check("latency_valid", data_out_tvalid, ONE_CYCLE);
    drain();

    // Full table load 0x1000+i, then one sequential 256-beat packet with a stall.
    g_ld_base = 'h1000; g_ld_len = 256; g_ld_idx = 0;
    run(0, 256, 0, 100, 100);
    check("pending_after_load", swap_pending, 1'b1);
    drive_and_tick(0, 100, 0, 0, 0, ai, al);
    check("bank_after_swap", active_bank, 1'b1);
    g_seq = 1'b1; g_pkt = 256; g_in_idx = 0;
    run(100, 0, 100, 100, 0);
    for (int i = 0; i < 5; i++) begin
      drive_and_tick(100, 0, 0, 1, 0, ai, al);
      if (ONE_CYCLE) check("stall_no_accept", ai, 1'b0);
    end
    run(156, 0, 100, 100, 0);
    drain();

    // Second load completes while a 64-beat packet is open.
    g_seq = 1'b0; g_pkt = 64; g_in_idx = 0;
    run(32, 0, 80, 80, 0);
    g_ld_base = 'h2000; g_ld_len = 256; g_ld_idx = 0;
    run(0, 256, 0, 80, 90);
    check("pending_open_pkt", swap_pending, 1'b1);
    check("bank_open_pkt", active_bank, 1'b1);
    run(96, 0, 80, 80, 0);
    drain();
    check("bank_after_pkt", active_bank, 1'b0);

    // Over-long load: 260 beats, tlast on the last.
    g_ld_base = 'h3000; g_ld_len = 260; g_ld_idx = 0;
    run(0, 260, 0, 100, 100);
    check("overflow_set", load_overflow, 1'b1);
    drive_and_tick(0, 100, 0, 0, 0, ai, al);
    check("bank_after_ovf", active_bank, 1'b1);
    g_pkt = 32; g_in_idx = 0;
    run(128, 0, 90, 70, 0);
    drain();

    // Concurrent random loads and lookups.
    for (int k = 0; k < 4; k++) begin
      g_ld_base = 'h4000 + k * 'h400;
      g_ld_len  = $urandom_range(300, 1);
      g_ld_idx  = 0;
      g_pkt     = $urandom_range(40, 1);
      g_in_idx  = 0;
      run(g_pkt * $urandom_range(6, 2), g_ld_len,
          $urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100, 20));
    end
    drain();

    // Reset during load beat 100 with an output beat in flight.
    g_ld_base = 'h6000; g_ld_len = 200; g_ld_idx = 0;
    run(0, 99, 0, 100, 100);
    g_pkt = 8; g_in_idx = 0;
    drive_and_tick(100, 0, 0, 1, 0, ai, al);
    data_load_tvalid = 1'b1;
    data_load_tdata  = DW'(g_ld_base + g_ld_idx);
    data_load_tlast  = 1'b0;
    data_out_tready  = 1'b0;
    #1;
    check("pre_reset_valid", data_out_tvalid, ONE_CYCLE);
    aresetn = 1'b0;
    #1;
    check("mid_rst_out_valid", data_out_tvalid, 1'b0);
    check("mid_rst_out_last", data_out_tlast, 1'b0);
    check("mid_rst_bank", active_bank, 1'b0);
    check("mid_rst_pending", swap_pending, 1'b0);
    check("mid_rst_overflow", load_overflow, 1'b0);
    m_active = 1'b0; m_pending = 1'b0; m_ovf = 1'b0; m_in_pkt = 1'b0; m_ld_cnt = 0;
    exp_q.delete();
    prev_stall = 1'b0;
    data_in_tvalid = 1'b0; data_load_tvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    g_ld_base = 'h7000; g_ld_len = 4; g_ld_idx = 0;
    run(0, 4, 0, 100, 100);
    drive_and_tick(0, 100, 0, 0, 0, ai, al);
    check("post_rst_bank", active_bank, 1'b1);
    g_seq = 1'b1; g_pkt = 4; g_in_idx = 0;
    run(4, 0, 100, 100, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
